// File: rtl/qrd_feed_pkg.sv
// ----------------------------------------------------------------------------
// qrd_feed_pkg
// Shared definitions for the QRD-RLS snapshot feeder: default sample width,
// tap count of the 4x4 systolic array, feeder FSM states, the FIFO entry
// layout and the most-negative / most-negative+1 clip codes.
// ----------------------------------------------------------------------------
package qrd_feed_pkg;

    localparam int DATA_LENGTH_DEF = 8;
    // Snapshot length; the downstream array is 4x4, so this is fixed.
    localparam int TAPS = 4;

    typedef enum logic [1:0] {
        PRIME = 2'd0,   // filling the tap line, no snapshots issued
        READY = 2'd1,   // next pop issues a snapshot
        WAIT  = 2'd2    // pacing the array's per-snapshot throughput
    } feed_state_t;

    typedef struct packed {
        logic [DATA_LENGTH_DEF-1:0] x;
        logic [DATA_LENGTH_DEF-1:0] d;
    } fifo_entry_t;

    localparam logic [DATA_LENGTH_DEF-1:0] SAMPLE_MIN    = {1'b1, {(DATA_LENGTH_DEF-1){1'b0}}};
    localparam logic [DATA_LENGTH_DEF-1:0] SAMPLE_MIN_P1 = SAMPLE_MIN + 1'b1;

endpackage

// File: rtl/qrd_feed_fifo.sv
// ----------------------------------------------------------------------------
// qrd_feed_fifo
// Synchronous FIFO holding (x, d) sample pairs ahead of the tap line.
// Read data is the head entry, presented combinationally (show-ahead).
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   i_flush     synchronous clear of pointers and occupancy
//   i_push      write i_data (caller guarantees not full)
//   i_pop       drop head entry (caller guarantees not empty)
//   o_data      head entry
//   o_count     occupancy, 0..DEPTH
//   o_full      occupancy == DEPTH
//   o_empty     occupancy == 0
// ----------------------------------------------------------------------------
module qrd_feed_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/qrd_snapshot_feeder.sv
// ----------------------------------------------------------------------------
// qrd_snapshot_feeder
// Upstream stage of the 4x4 QRD-RLS systolic array. Buffers (x, d) pairs in
// a FIFO, shifts x through a 4-deep tap line and drives the snapshot
// {x[n], x[n-1], x[n-2], x[n-3]} plus d[n] onto the array, with one arr_start
// pulse per snapshot, spaced at least ISSUE_GAP cycles apart.
// Optional feature macro: QRD_FEED_CLIP_EN (clip most-negative code to
// most-negative+1 on entry and raise sticky clip_seen).
// Ports:
//   clk, rst         clock / synchronous active-high reset
//   s_valid/s_ready  sample-pair handshake; s_x, s_d sample inputs
//   flush            synchronous clear of FIFO, taps and priming
//   arr_bc1..arr_ic3 x[n]..x[n-3] to the array; arr_sk d[n]
//   arr_start        1-cycle snapshot start pulse
//   fifo_level       FIFO occupancy
//   clip_seen        sticky clip flag (0 when the clip feature is off)
// ----------------------------------------------------------------------------
module qrd_snapshot_feeder
    import qrd_feed_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int ISSUE_GAP   = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_LENGTH-1:0]        s_x,
    input  logic [DATA_LENGTH-1:0]        s_d,
    input  logic                          flush,
    output logic [DATA_LENGTH-1:0]        arr_bc1,
    output logic [DATA_LENGTH-1:0]        arr_ic1,
    output logic [DATA_LENGTH-1:0]        arr_ic2,
    output logic [DATA_LENGTH-1:0]        arr_ic3,
    output logic [DATA_LENGTH-1:0]        arr_sk,
    output logic                          arr_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          clip_seen
);

    localparam int GW         = $clog2(ISSUE_GAP);
    localparam int PRIME_POPS = TAPS - 1;   // pops needed before the first full snapshot

    feed_state_t              r_state;
    feed_state_t              w_state_nxt;
    logic [GW-1:0]            r_gap_cnt;
    logic [1:0]               r_prime_cnt;
    logic                     r_start;
    logic [DATA_LENGTH-1:0]   r_tap0, r_tap1, r_tap2, r_tap3, r_d;

    logic                     w_push, w_pop, w_issue, w_full, w_empty;
    logic [DATA_LENGTH-1:0]   w_x_in, w_d_in;
    logic [2*DATA_LENGTH-1:0] w_head;

    // flush wins over a same-cycle push; the offered pair is dropped.
    assign s_ready = !w_full;
    assign w_push  = s_valid && s_ready && !flush;

`ifdef QRD_FEED_CLIP_EN
    localparam logic [DATA_LENGTH-1:0] W_MIN    = {1'b1, {(DATA_LENGTH-1){1'b0}}};
    localparam logic [DATA_LENGTH-1:0] W_MIN_P1 = W_MIN + 1'b1;

    logic r_clip_seen;

    // Keep the range symmetric so the array never sees -1.0.
    assign w_x_in = (s_x == W_MIN) ? W_MIN_P1 : s_x;
    assign w_d_in = (s_d == W_MIN) ? W_MIN_P1 : s_d;

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_clip_seen <= 1'b0;
        else if (w_push && ((s_x == W_MIN) || (s_d == W_MIN)))
            r_clip_seen <= 1'b1;
    end

    assign clip_seen = r_clip_seen;
`else
    assign w_x_in    = s_x;
    assign w_d_in    = s_d;
    assign clip_seen = 1'b0;
`endif

    qrd_feed_fifo #(
        .WIDTH (2*DATA_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  ({w_x_in, w_d_in}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst || flush) r_state <= PRIME;
        else              r_state <= w_state_nxt;
    end

    // ---- FSM: next state ----
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRIME:   if (!w_empty && r_prime_cnt == 2'(PRIME_POPS-1)) w_state_nxt = READY;
            READY:   if (!w_empty && r_gap_cnt == '0)                 w_state_nxt = WAIT;
            // Leave one cycle early: the counter reaches 0 as READY is entered,
            // which makes consecutive pulses exactly ISSUE_GAP cycles apart.
            WAIT:    if (r_gap_cnt <= GW'(1))                         w_state_nxt = READY;
            default: w_state_nxt = PRIME;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_pop   = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            PRIME: w_pop = !w_empty;
            READY: begin
                w_pop   = !w_empty && (r_gap_cnt == '0);
                w_issue = w_pop;
            end
            default: ;
        endcase
    end

    // ---- Tap line, d register, pacing and priming counters ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_tap0      <= '0;
            r_tap1      <= '0;
            r_tap2      <= '0;
            r_tap3      <= '0;
            r_d         <= '0;
            r_start     <= 1'b0;
            r_gap_cnt   <= '0;
            r_prime_cnt <= '0;
        end else begin
            // Registered so the pulse lines up with the freshly shifted taps.
            r_start <= w_issue;

            if (w_pop) begin
                r_tap3 <= r_tap2;
                r_tap2 <= r_tap1;
                r_tap1 <= r_tap0;
                r_tap0 <= w_head[2*DATA_LENGTH-1:DATA_LENGTH];
                r_d    <= w_head[DATA_LENGTH-1:0];
            end

            if (r_state == PRIME && w_pop)
                r_prime_cnt <= (r_prime_cnt == 2'(PRIME_POPS-1)) ? 2'd0 : r_prime_cnt + 2'd1;

            if (w_issue)
                r_gap_cnt <= GW'(ISSUE_GAP-1);
            else if (r_state == WAIT && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    assign arr_bc1   = r_tap0;
    assign arr_ic1   = r_tap1;
    assign arr_ic2   = r_tap2;
    assign arr_ic3   = r_tap3;
    assign arr_sk    = r_d;
    assign arr_start = r_start;

endmodule
